// File: rtl/alu_muldiv_pkg.sv
// Shared ALU-op codes, multiply/divide FSM state encodings and helpers for alu_muldiv.
package alu_muldiv_pkg;

  localparam logic [7:0] ALUOP_MFHI  = 8'h10;
  localparam logic [7:0] ALUOP_MTHI  = 8'h11;
  localparam logic [7:0] ALUOP_MFLO  = 8'h12;
  localparam logic [7:0] ALUOP_MTLO  = 8'h13;
  localparam logic [7:0] ALUOP_MULT  = 8'h18;
  localparam logic [7:0] ALUOP_MULTU = 8'h19;
  localparam logic [7:0] ALUOP_DIV   = 8'h1A;
  localparam logic [7:0] ALUOP_DIVU  = 8'h1B;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Magnitude of v when interpreted as signed; raw value for unsigned ops.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/alu_muldiv_div_radix2.sv
// Restoring radix-2 divider datapath: remainder/quotient shift register and iteration down-counter.
module alu_muldiv_div_radix2 #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   rem_q, quo_q, dsr_q;
  logic [32:0]   shifted, diff;
  logic          ge;

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    ge      = shifted >= {1'b0, dsr_q};
    diff    = shifted - {1'b0, dsr_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      cnt   <= CW'(DIV_CYCLES);
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (cnt != '0) begin
      cnt   <= cnt - CW'(1);
      rem_q <= ge ? diff[31:0] : shifted[31:0];
      quo_q <= {quo_q[30:0], ge};
    end
  end

  // Terminal count: the last iteration completes at the coming edge.
  assign done      = (cnt == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage multiply/divide unit owning HI/LO; stalls the pipeline while busy.
// Optional MULDIV_DIV0_FAST_EN: a zero divisor skips the iterations and goes straight to DONE.
//
// state   | meaning
// IDLE    | accepts MULT/DIV, performs MTHI/MTLO
// MUL     | product registered, one stall cycle
// DIV     | divider iterating
// DONE    | no stall; HI/LO written at the closing edge
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushE,
  input  logic        validE,
  input  logic [7:0]  aluopE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  output logic        stall_muldiv,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e          state, state_nxt;
  logic               go, start, is_mul_op, is_div_op, is_signed_op, div_start, div_done;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic [63:0]        prod_q;
  logic               op_div_q, neg_q_q, neg_r_q;
  logic [31:0]        mag_a, mag_b, div_quo, div_rem, raw_quo, raw_rem, res_quo, res_rem;
  logic [31:0]        hi_q, lo_q, hi_d, lo_d;
`ifdef MULDIV_DIV0_FAST_EN
  logic               div0_q;
  logic [31:0]        mag_a_q;
`endif

  always_comb begin
    is_mul_op    = (aluopE == ALUOP_MULT) || (aluopE == ALUOP_MULTU);
    is_div_op    = (aluopE == ALUOP_DIV)  || (aluopE == ALUOP_DIVU);
    is_signed_op = (aluopE == ALUOP_MULT) || (aluopE == ALUOP_DIV);
    go           = validE && !flushE;
    start        = go && (is_mul_op || is_div_op) && (state == MD_IDLE);
    mul_a        = {is_signed_op && srcaE[31], srcaE};
    mul_b        = {is_signed_op && srcbE[31], srcbE};
    prod         = mul_a * mul_b;
    mag_a        = abs32(srcaE, is_signed_op);
    mag_b        = abs32(srcbE, is_signed_op);
  end

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      MD_IDLE: begin
        if (go && is_mul_op) begin
          state_nxt = MD_MUL;
        end else if (go && is_div_op) begin
`ifdef MULDIV_DIV0_FAST_EN
          if (srcbE == '0) begin
            state_nxt = MD_DONE;
          end else begin
            state_nxt = MD_DIV;
            div_start = 1'b1;
          end
`else
          state_nxt = MD_DIV;
          div_start = 1'b1;
`endif
        end
      end
      MD_MUL:  state_nxt = MD_DONE;
      MD_DIV:  if (div_done) state_nxt = MD_DONE;
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
    if (flushE) state_nxt = MD_IDLE;
  end

  assign stall_muldiv = (start || state == MD_MUL || state == MD_DIV) && !flushE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MD_IDLE;
    else      state <= state_nxt;
  end

  // Operands and sign fix-up flags are captured once, in the accept cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q   <= '0;
      op_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
`ifdef MULDIV_DIV0_FAST_EN
      div0_q   <= 1'b0;
      mag_a_q  <= '0;
`endif
    end else if (start) begin
      prod_q   <= prod;
      op_div_q <= is_div_op;
      neg_q_q  <= is_signed_op && (srcaE[31] ^ srcbE[31]);
      neg_r_q  <= is_signed_op && srcaE[31];
`ifdef MULDIV_DIV0_FAST_EN
      div0_q   <= is_div_op && (srcbE == '0);
      mag_a_q  <= mag_a;
`endif
    end
  end

  alu_muldiv_div_radix2 #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flushE),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    raw_quo = div_quo;
    raw_rem = div_rem;
`ifdef MULDIV_DIV0_FAST_EN
    // Same values the iterative path would produce for a zero divisor.
    if (div0_q) begin
      raw_quo = 32'hFFFF_FFFF;
      raw_rem = mag_a_q;
    end
`endif
    res_quo = neg_q_q ? (32'd0 - raw_quo) : raw_quo;
    res_rem = neg_r_q ? (32'd0 - raw_rem) : raw_rem;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!flushE) begin
      if (state == MD_IDLE && validE) begin
        if (aluopE == ALUOP_MTHI) hi_d = srcaE;
        if (aluopE == ALUOP_MTLO) lo_d = srcaE;
      end else if (state == MD_DONE) begin
        if (op_div_q) begin
          hi_d = res_rem;
          lo_d = res_quo;
        end else begin
          hi_d = prod_q[63:32];
          lo_d = prod_q[31:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    hilo_rdata = '0;
    if (aluopE == ALUOP_MFHI)      hilo_rdata = hi_q;
    else if (aluopE == ALUOP_MFLO) hilo_rdata = lo_q;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv; expected values are hand-computed constants.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flushE = 1'b0;
  logic        validE = 1'b0;
  logic [7:0]  aluopE = 8'h00;
  logic [31:0] srcaE = '0;
  logic [31:0] srcbE = '0;
  logic        stall_muldiv;
  logic [31:0] hilo_rdata, hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  localparam int MUL_STALL = 2;
  localparam int DIV_STALL = 33;
`ifdef MULDIV_DIV0_FAST_EN
  localparam int DIV0_STALL = 1;
`else
  localparam int DIV0_STALL = 33;
`endif

  alu_muldiv dut (
    .clk          (clk),
    .rst          (rst),
    .flushE       (flushE),
    .validE       (validE),
    .aluopE       (aluopE),
    .srcaE        (srcaE),
    .srcbE        (srcbE),
    .stall_muldiv (stall_muldiv),
    .hilo_rdata   (hilo_rdata),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1, presents one op and waits through DONE; ends at posedge+1 in IDLE.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nst, output logic first);
    aluopE = op;
    srcaE  = a;
    srcbE  = b;
    validE = 1'b1;
    #1;
    first = stall_muldiv;
    nst   = 0;
    while (stall_muldiv === 1'b1 && nst < 100) begin
      nst++;
      tick();
    end
    tick();
    validE = 1'b0;
    aluopE = 8'h00;
  endtask

  task automatic mt(input logic [7:0] op, input logic [31:0] d);
    aluopE = op;
    srcaE  = d;
    validE = 1'b1;
    #1;
    chk("mt_no_stall", {31'd0, stall_muldiv}, 32'd0);
    tick();
    validE = 1'b0;
    aluopE = 8'h00;
  endtask

  initial begin
    int   n;
    logic f;

    aluopE = ALUOP_MFHI;
    repeat (2) tick();
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_stall", {31'd0, stall_muldiv}, 32'd0);
    chk("rst_rdata", hilo_rdata, 32'h0);
    rst = 1'b1;
    aluopE = 8'h00;
    tick();

    run_op(ALUOP_MULT, 32'hFFFF_FFFE, 32'd3, n, f);
    chk("mult_first_stall", {31'd0, f}, 32'd1);
    chk("mult_stall", 32'(n), 32'(MUL_STALL));
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFFA);

    run_op(ALUOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, f);
    chk("multu_stall", 32'(n), 32'(MUL_STALL));
    chk("multu_hi", hi_o, 32'hFFFF_FFFE);
    chk("multu_lo", lo_o, 32'h0000_0001);

    run_op(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, n, f);
    chk("div_stall", 32'(n), 32'(DIV_STALL));
    chk("div_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_hi", hi_o, 32'hFFFF_FFFF);

    // Presented in the cycle right after DONE: must be accepted immediately.
    run_op(ALUOP_MULT, 32'h0001_0000, 32'h0001_0000, n, f);
    chk("b2b_first_stall", {31'd0, f}, 32'd1);
    chk("b2b_stall", 32'(n), 32'(MUL_STALL));
    chk("b2b_hi", hi_o, 32'h0000_0001);
    chk("b2b_lo", lo_o, 32'h0000_0000);

    run_op(ALUOP_DIVU, 32'd7, 32'd2, n, f);
    chk("divu_stall", 32'(n), 32'(DIV_STALL));
    aluopE = ALUOP_MFLO;
    #1;
    chk("divu_mflo", hilo_rdata, 32'd3);
    aluopE = ALUOP_MFHI;
    #1;
    chk("divu_mfhi", hilo_rdata, 32'd1);
    aluopE = ALUOP_MULT;
    #1;
    chk("unlisted_rdata", hilo_rdata, 32'd0);
    aluopE = 8'h00;
    tick();

    run_op(ALUOP_DIV, 32'd7, 32'hFFFF_FFFE, n, f);
    chk("div_negb_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_negb_hi", hi_o, 32'd1);

    run_op(ALUOP_DIVU, 32'd5, 32'd0, n, f);
    chk("divu0_stall", 32'(n), 32'(DIV0_STALL));
    chk("divu0_lo", lo_o, 32'hFFFF_FFFF);
    chk("divu0_hi", hi_o, 32'd5);

    run_op(ALUOP_DIV, 32'hFFFF_FFF8, 32'd0, n, f);
    chk("div0_neg_stall", 32'(n), 32'(DIV0_STALL));
    chk("div0_neg_lo", lo_o, 32'h0000_0001);
    chk("div0_neg_hi", hi_o, 32'hFFFF_FFF8);

    mt(ALUOP_MTHI, 32'hDEAD_BEEF);
    aluopE = ALUOP_MFHI;
    #1;
    chk("mfhi_rdata", hilo_rdata, 32'hDEAD_BEEF);
    chk("mfhi_no_stall", {31'd0, stall_muldiv}, 32'd0);
    aluopE = 8'h00;

    mt(ALUOP_MTHI, 32'h1234_5678);
    mt(ALUOP_MTLO, 32'h1234_5678);
    chk("preset_hi", hi_o, 32'h1234_5678);
    chk("preset_lo", lo_o, 32'h1234_5678);

    aluopE = ALUOP_DIV;
    srcaE  = 32'd100;
    srcbE  = 32'd3;
    validE = 1'b1;
    #1;
    chk("flush_accept_stall", {31'd0, stall_muldiv}, 32'd1);
    repeat (10) tick();
    flushE = 1'b1;
    #1;
    chk("flush_stall_drop", {31'd0, stall_muldiv}, 32'd0);
    tick();
    flushE = 1'b0;
    validE = 1'b0;
    aluopE = 8'h00;
    #1;
    chk("flush_state_idle", 32'(dut.state), 32'(MD_IDLE));
    chk("flush_stall_after", {31'd0, stall_muldiv}, 32'd0);
    repeat (40) tick();
    chk("flush_hi_kept", hi_o, 32'h1234_5678);
    chk("flush_lo_kept", lo_o, 32'h1234_5678);

    aluopE = ALUOP_DIVU;
    srcaE  = 32'd9;
    srcbE  = 32'd4;
    validE = 1'b1;
    flushE = 1'b1;
    #1;
    chk("flush_on_accept_stall", {31'd0, stall_muldiv}, 32'd0);
    tick();
    flushE = 1'b0;
    validE = 1'b0;
    #1;
    chk("flush_on_accept_idle", 32'(dut.state), 32'(MD_IDLE));

    validE = 1'b1;
    #1;
    tick();
    tick();
    validE = 1'b0;
    aluopE = 8'h00;
    rst = 1'b0;
    #1;
    chk("midop_rst_stall", {31'd0, stall_muldiv}, 32'd0);
    chk("midop_rst_hi", hi_o, 32'h0);
    chk("midop_rst_lo", lo_o, 32'h0);
    chk("midop_rst_state", 32'(dut.state), 32'(MD_IDLE));
    tick();
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
